// File: rtl/rv32i_control_fsm_if.sv
// Control-FSM port bundle: decoded opcode and memory handshake in, datapath strobes/selects out.
interface rv32i_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic [1:0]       pc_op;
    logic             pc_write;
    logic             ir_write;
    logic             reg_write;
    logic             mem_req;
    logic             mem_we;
    logic             mem_addr_sel;
    logic [1:0]       alu_a_sel;
    logic [1:0]       alu_b_sel;
    logic [1:0]       alu_op;
    logic [1:0]       wb_sel;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, mem_ready,
        output pc_op, pc_write, ir_write, reg_write, mem_req, mem_we, mem_addr_sel,
               alu_a_sel, alu_b_sel, alu_op, wb_sel, halted, illegal, instret
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_op, pc_write, ir_write, reg_write, mem_req, mem_we, mem_addr_sel,
               alu_a_sel, alu_b_sel, alu_op, wb_sel, halted, illegal, instret
    );
endinterface

// File: rtl/rv32i_control_fsm.sv
// Multicycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing, memory handshake,
// halt/illegal detection and retired-instruction counting.
//
// state  | meaning
// FETCH  | request instruction at PC, load IR and PC+4 on mem_ready
// DECODE | compute old_pc+imm into alu_out, dispatch on opcode
// EXEC   | ALU operation, branch/jump PC update
// MEM    | load/store access at alu_out, held until mem_ready
// WB     | register-file write
// HALT   | ECALL/EBREAK or illegal opcode, terminal until rst
module rv32i_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    rv32i_control_fsm_if.master  bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    state_t           r_state;
    logic             r_halted;
    logic             r_illegal;
    logic [CNT_W-1:0] r_instret;

    state_t     w_next;
    logic       w_retire;
    logic       w_set_halt;
    logic       w_set_ill;
    logic [1:0] w_pc_op;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_mem_addr_sel;
    logic [1:0] w_alu_a_sel;
    logic [1:0] w_alu_b_sel;
    logic [1:0] w_alu_op;
    logic [1:0] w_wb_sel;

    always_comb begin
        w_next         = r_state;
        w_set_halt     = 1'b0;
        w_set_ill      = 1'b0;
        w_pc_op        = 2'b00;
        w_pc_write     = 1'b0;
        w_ir_write     = 1'b0;
        w_reg_write    = 1'b0;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr_sel = 1'b0;
        w_alu_a_sel    = 2'b00;
        w_alu_b_sel    = 2'b00;
        w_alu_op       = 2'b00;
        w_wb_sel       = 2'b00;

        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_a_sel = 2'b01;
                w_alu_b_sel = 2'b10;
                if (bus.mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_a_sel = 2'b01;
                w_alu_b_sel = 2'b01;
                case (bus.opcode)
                    OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE,
                    OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_AUIPC: w_next = S_EXEC;
                    OPC_LUI:    w_next = S_WB;
                    OPC_FENCE:  w_next = S_FETCH;
                    OPC_SYSTEM: begin
                        w_next     = S_HALT;
                        w_set_halt = 1'b1;
                    end
                    default: begin
                        w_next    = S_HALT;
                        w_set_ill = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                case (bus.opcode)
                    OPC_OP: begin
                        w_alu_op = 2'b10;
                        w_next   = S_WB;
                    end
                    OPC_OP_IMM: begin
                        w_alu_b_sel = 2'b01;
                        w_alu_op    = 2'b11;
                        w_next      = S_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        w_alu_b_sel = 2'b01;
                        w_next      = S_MEM;
                    end
                    OPC_AUIPC: begin
                        w_alu_a_sel = 2'b01;
                        w_alu_b_sel = 2'b01;
                        w_next      = S_WB;
                    end
                    OPC_BRANCH: begin
                        w_alu_op   = 2'b01;
                        w_pc_op    = 2'b01;
                        w_pc_write = 1'b1;
                        w_next     = S_FETCH;
                    end
                    OPC_JAL: begin
                        w_pc_op     = 2'b10;
                        w_pc_write  = 1'b1;
                        w_reg_write = 1'b1;
                        w_wb_sel    = 2'b10;
                        w_next      = S_FETCH;
                    end
                    OPC_JALR: begin
                        w_alu_b_sel = 2'b01;
                        w_pc_op     = 2'b11;
                        w_pc_write  = 1'b1;
                        w_reg_write = 1'b1;
                        w_wb_sel    = 2'b10;
                        w_next      = S_FETCH;
                    end
                    default: begin
                        w_next    = S_HALT;
                        w_set_ill = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                w_mem_req      = 1'b1;
                w_mem_addr_sel = 1'b1;
                w_mem_we       = (bus.opcode == OPC_STORE);
                if (bus.mem_ready) begin
                    w_next = (bus.opcode == OPC_STORE) ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                if (bus.opcode == OPC_LOAD) begin
                    w_wb_sel = 2'b01;
                end else if (bus.opcode == OPC_LUI) begin
                    w_wb_sel = 2'b11;
                end
                w_next = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        w_retire = (w_next == S_FETCH) &&
                   ((r_state == S_DECODE) || (r_state == S_EXEC) ||
                    (r_state == S_MEM)    || (r_state == S_WB));

        // Reset must never let a write or memory request escape, whatever state was in flight.
        if (rst) begin
            w_pc_write  = 1'b0;
            w_ir_write  = 1'b0;
            w_reg_write = 1'b0;
            w_mem_req   = 1'b0;
            w_mem_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_set_halt) r_halted <= 1'b1;
            if (w_set_ill)  r_illegal <= 1'b1;
            if (w_retire)   r_instret <= r_instret + 1'b1;
        end
    end

    assign bus.pc_op        = w_pc_op;
    assign bus.pc_write     = w_pc_write;
    assign bus.ir_write     = w_ir_write;
    assign bus.reg_write    = w_reg_write;
    assign bus.mem_req      = w_mem_req;
    assign bus.mem_we       = w_mem_we;
    assign bus.mem_addr_sel = w_mem_addr_sel;
    assign bus.alu_a_sel    = w_alu_a_sel;
    assign bus.alu_b_sel    = w_alu_b_sel;
    assign bus.alu_op       = w_alu_op;
    assign bus.wb_sel       = w_wb_sel;
    assign bus.halted       = r_halted;
    assign bus.illegal      = r_illegal;
    assign bus.instret      = r_instret;
endmodule

// File: doc/rv32i_control_fsm.md
Name: rv32i_control_fsm

Overview:
- Main multicycle control state machine for the RV32I core.
- Sequences each instruction through the fetch, decode, execute, memory and writeback states.
- Generates every datapath strobe and the 2-bit pc_op consumed by the branch unit, which resolves it into pcsrc.
- Runs a request/ready handshake with the unified memory port, detects halt and illegal opcodes, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- opcode  in  7  IR[6:0]; stable from DECODE onward.
- mem_ready  in  1  memory completes the current request this cycle.
- pc_op  out  2  PC source request to the branch unit. 00=PC+4, 01=conditional branch (alu_out reg), 10=JAL target (alu_out reg), 11=JALR target (live ALU result).
- pc_write  out  1  PC register load enable.
- ir_write  out  1  IR and old_pc load enable.
- reg_write  out  1  register-file write enable.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write; valid only with mem_req.
- mem_addr_sel  out  1  memory address source. 0=PC, 1=alu_out reg.
- alu_a_sel  out  2  ALU A source. 00=rs1, 01=old_pc, 10=zero.
- alu_b_sel  out  2  ALU B source. 00=rs2, 01=imm, 10=const 4.
- alu_op  out  2  ALU operation. 00=add, 01=subtract/compare, 10=R-type funct decode, 11=I-type funct decode.
- wb_sel  out  2  writeback source. 00=alu_out reg, 01=mem data reg, 10=PC (already incremented, i.e. old_pc+4), 11=imm.
- halted  out  1  ECALL/EBREAK reached; sticky.
- illegal  out  1  unsupported opcode reached; sticky.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Clock and reset are fixed: one clock; reset is synchronous and active-high, ports named clk and rst.
- While rst is high, all strobes are forced to 0: pc_write, ir_write, reg_write, mem_req, mem_we.
- On the reset edge: state=FETCH, instret=0, halted=0, illegal=0.
- Reset mid-operation abandons the instruction. No strobe is issued in the reset cycle.
- Strobes not listed for a state are 0. Unlisted selects default to 00.
- Strobes are decoded combinationally from the state register and opcode, except ir_write and pc_write in FETCH, which are gated by mem_ready.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr_sel=0, alu_a_sel=01, alu_b_sel=10, pc_op=00.
  - mem_req holds high until mem_ready is sampled high.
  - On mem_ready: ir_write=1, pc_write=1, next state DECODE. Otherwise stay in FETCH.
- DECODE:
  - alu_a_sel=01, alu_b_sel=01, alu_op=00; branch/JAL target is latched into the alu_out reg.
  - Next state EXEC for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0010111.
  - 0110111 (LUI) goes directly to WB.
  - 0001111 (FENCE) goes to FETCH as a NOP and retires.
  - 1110011 (SYSTEM) goes to HALT with halted=1.
  - Any other opcode goes to HALT with illegal=1.
- EXEC, by opcode:
  - OP: a=00, b=00, alu_op=10. Next WB.
  - OP-IMM: a=00, b=01, alu_op=11. Next WB.
  - LOAD/STORE: a=00, b=01, alu_op=00. Next MEM.
  - AUIPC: a=01, b=01, alu_op=00. Next WB.
  - BRANCH: a=00, b=00, alu_op=01, pc_op=01, pc_write=1. The branch unit decides the redirect. Next FETCH.
  - JAL: pc_op=10, pc_write=1, reg_write=1, wb_sel=10. Next FETCH.
  - JALR: a=00, b=01, alu_op=00, pc_op=11, pc_write=1, reg_write=1, wb_sel=10. Next FETCH.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for STORE and 0 for LOAD; held until mem_ready.
  - On mem_ready: LOAD goes to WB, STORE goes to FETCH.
- WB:
  - reg_write=1. wb_sel=01 for LOAD, 11 for LUI, 00 otherwise.
  - Next FETCH.
- HALT:
  - All strobes 0. Terminal until rst.
  - halted/illegal stay set. instret does not count the halting instruction.
- Retirement:
  - instret increments by 1 on every transition into FETCH from DECODE, EXEC, MEM or WB.
  - instret wraps modulo 2^CNT_W.
- Zero-wait latency in cycles: BRANCH/JAL/JALR 3, OP/OP-IMM/AUIPC 4, LUI 3, FENCE 2, STORE 4, LOAD 5. Each wait cycle on mem_ready adds 1.
- Encoding: state register 3 bits. FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6–7 recover to FETCH.

Test Plan:
- Reset, then ADD (0110011) with mem_ready always 1: exactly one 1-cycle pulse each of ir_write+pc_write (pc_op=00), then alu_op=10, then reg_write with wb_sel=00. instret=1 after 4 cycles.
- LOAD with mem_ready low for 3 cycles in both FETCH and MEM: mem_req held high and stable across both waits. WB has wb_sel=01. Total 11 cycles; instret=1.
- BRANCH followed by JALR: BRANCH EXEC shows pc_op=01, pc_write=1, reg_write=0. JALR EXEC shows pc_op=11, pc_write=1, reg_write=1, wb_sel=10. Each takes 3 cycles.
- Opcode 1111111: after DECODE, illegal=1, state stays HALT for 20 cycles with all strobes 0, instret unchanged. rst clears illegal and resumes FETCH.
- ECALL (1110011) sets halted=1, illegal=0. STORE sequence shows mem_we=1 only in MEM with mem_addr_sel=1.
- rst asserted in the MEM cycle of a STORE: mem_req=0 that cycle, next cycle FETCH with instret=0. Also preload instret near max (CNT_W=4, 16 FENCEs): wraps to 0.
